// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_pkg
// Description : Shared types and encodings for the RV32I multicycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } cu_state_t;

    // Sequencing class: decides what follows EXECUTE
    typedef enum logic [1:0] {
        CLS_WB     = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } cu_class_t;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    localparam logic [3:0] c_ALU_ADD   = 4'b0000;
    localparam logic [3:0] c_ALU_SUB   = 4'b1000;
    localparam logic [3:0] c_ALU_SRA   = 4'b1101;
    localparam logic [3:0] c_ALU_PASSB = 4'b1111;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_U = 3'b010;
    localparam logic [2:0] c_IMM_B = 3'b101;
    localparam logic [2:0] c_IMM_J = 3'b110;

    localparam logic [4:0] c_BU_PC4      = 5'b00000;
    localparam logic [4:0] c_BU_JUMP     = 5'b10000;
    localparam logic [1:0] c_BU_COND_PFX = 2'b01;

    localparam logic [1:0] c_WB_ALU = 2'b00;
    localparam logic [1:0] c_WB_MEM = 2'b01;
    localparam logic [1:0] c_WB_PC4 = 2'b10;

    localparam logic [1:0] c_TC_NONE    = 2'd0;
    localparam logic [1:0] c_TC_ILLEGAL = 2'd1;
    localparam logic [1:0] c_TC_IFETCH  = 2'd2;
    localparam logic [1:0] c_TC_DATA    = 2'd3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] imm_src;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [4:0] bu_op;
        logic [1:0] ru_data_wr_src;
    } cu_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/cu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cu_decoder
// Description : Combinational RV32I decode to datapath controls, class, illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_decoder
    import cu_pkg::*;
#(
    parameter bit SUPPORT_UI = 1'b1
) (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    output cu_ctrl_t   o_ctrl,
    output cu_class_t  o_cls,
    output logic       o_illegal
);

    logic w_f7_base;
    logic w_f7_alt;

    assign w_f7_base = (i_func7 == c_F7_BASE);
    assign w_f7_alt  = (i_func7 == c_F7_ALT);

    always_comb begin
        o_ctrl    = '0;
        o_cls     = CLS_WB;
        o_illegal = 1'b0;
        case (i_opcode)
            c_OP_R: begin
                // ALUOp low bits follow func3 directly; func7 selects SUB/SRA
                o_ctrl.alu_op = {1'b0, i_func3};
                if (w_f7_alt) begin
                    if (i_func3 == 3'b000)      o_ctrl.alu_op = c_ALU_SUB;
                    else if (i_func3 == 3'b101) o_ctrl.alu_op = c_ALU_SRA;
                    else                        o_illegal     = 1'b1;
                end else if (!w_f7_base) begin
                    o_illegal = 1'b1;
                end
            end
            c_OP_I_ALU: begin
                o_ctrl.alu_op    = {1'b0, i_func3};
                o_ctrl.imm_src   = c_IMM_I;
                o_ctrl.alu_b_src = 1'b1;
                if (i_func3 == 3'b001 && !w_f7_base) o_illegal = 1'b1;
                if (i_func3 == 3'b101) begin
                    if (w_f7_alt)        o_ctrl.alu_op = c_ALU_SRA;
                    else if (!w_f7_base) o_illegal     = 1'b1;
                end
            end
            c_OP_LOAD: begin
                o_ctrl.alu_op         = c_ALU_ADD;
                o_ctrl.imm_src        = c_IMM_I;
                o_ctrl.alu_b_src      = 1'b1;
                o_ctrl.ru_data_wr_src = c_WB_MEM;
                o_cls                 = CLS_LOAD;
                o_illegal = (i_func3 == 3'b011) || (i_func3[2:1] == 2'b11);
            end
            c_OP_STORE: begin
                o_ctrl.alu_op    = c_ALU_ADD;
                o_ctrl.imm_src   = c_IMM_S;
                o_ctrl.alu_b_src = 1'b1;
                o_cls            = CLS_STORE;
                o_illegal        = (i_func3 > 3'b010);
            end
            c_OP_BRANCH: begin
                o_ctrl.alu_op    = c_ALU_ADD;
                o_ctrl.imm_src   = c_IMM_B;
                o_ctrl.alu_a_src = 1'b1;
                o_ctrl.alu_b_src = 1'b1;
                o_ctrl.bu_op     = {c_BU_COND_PFX, i_func3};
                o_cls            = CLS_BRANCH;
                o_illegal        = (i_func3[2:1] == 2'b01);
            end
            c_OP_JAL: begin
                o_ctrl.alu_op         = c_ALU_ADD;
                o_ctrl.imm_src        = c_IMM_J;
                o_ctrl.alu_a_src      = 1'b1;
                o_ctrl.alu_b_src      = 1'b1;
                o_ctrl.bu_op          = c_BU_JUMP;
                o_ctrl.ru_data_wr_src = c_WB_PC4;
            end
            c_OP_JALR: begin
                o_ctrl.alu_op         = c_ALU_ADD;
                o_ctrl.imm_src        = c_IMM_I;
                o_ctrl.alu_b_src      = 1'b1;
                o_ctrl.bu_op          = c_BU_JUMP;
                o_ctrl.ru_data_wr_src = c_WB_PC4;
            end
            c_OP_LUI: begin
                o_ctrl.alu_op    = c_ALU_PASSB;
                o_ctrl.imm_src   = c_IMM_U;
                o_ctrl.alu_b_src = 1'b1;
                o_illegal        = ~SUPPORT_UI;
            end
            c_OP_AUIPC: begin
                o_ctrl.alu_op    = c_ALU_ADD;
                o_ctrl.imm_src   = c_IMM_U;
                o_ctrl.alu_a_src = 1'b1;
                o_ctrl.alu_b_src = 1'b1;
                o_illegal        = ~SUPPORT_UI;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : cu_multicycle
// Description : RV32I multicycle control FSM with memory handshakes and traps.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter bit SUPPORT_UI  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             ImReady,
    input  logic             DmReady,
    output logic             ImReq,
    output logic             IrWr,
    output logic             PcWr,
    output logic             DmReq,
    output logic             DmWr,
    output logic [2:0]       DmCtrl,
    output logic [3:0]       ALUOp,
    output logic [2:0]       Immsrc,
    output logic             ALUAsrc,
    output logic             ALUBsrc,
    output logic [4:0]       BUOp,
    output logic             RuWr,
    output logic [1:0]       RuDataWrsrc,
    output logic             Trap,
    output logic [1:0]       TrapCause,
    output logic [CNT_W-1:0] RetireCnt
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);

    cu_state_t          r_state;
    cu_state_t          w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic [c_WAIT_W-1:0] w_wait_next;
    logic               w_waiting;
    logic               w_timeout;
    logic               r_trap;
    logic [1:0]         r_trap_cause;
    logic               w_trap_set;
    logic [1:0]         w_trap_cause;
    logic [CNT_W-1:0]   r_retire_cnt;
    logic               w_retire;

    logic w_im_req, w_ir_wr, w_pc_wr, w_dm_req, w_dm_wr, w_ru_wr, w_ctrl_en;

    cu_ctrl_t  w_dec_ctrl;
    cu_ctrl_t  w_ctrl_out;
    cu_class_t w_cls;
    logic      w_illegal;

    cu_decoder #(
        .SUPPORT_UI (SUPPORT_UI)
    ) u_decoder (
        .i_opcode  (Opcode),
        .i_func3   (func3),
        .i_func7   (func7),
        .o_ctrl    (w_dec_ctrl),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    // A Ready arriving in the final allowed cycle beats the timeout
    assign w_waiting   = ((r_state == ST_FETCH) && !ImReady) ||
                         ((r_state == ST_MEM)   && !DmReady);
    assign w_wait_inc  = r_wait_cnt + c_WAIT_W'(1);
    assign w_timeout   = (MEM_TIMEOUT > 0) && w_waiting && (w_wait_inc == c_TIMEOUT);
    assign w_wait_next = (w_waiting && (MEM_TIMEOUT > 0) && !w_timeout) ? w_wait_inc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_wait_cnt   <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= c_TC_NONE;
            r_retire_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            if (w_trap_set) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_trap_cause;
            end
            if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_im_req     = 1'b0;
        w_ir_wr      = 1'b0;
        w_pc_wr      = 1'b0;
        w_dm_req     = 1'b0;
        w_dm_wr      = 1'b0;
        w_ru_wr      = 1'b0;
        w_retire     = 1'b0;
        w_ctrl_en    = 1'b0;
        w_trap_set   = 1'b0;
        w_trap_cause = c_TC_NONE;
        case (r_state)
            ST_FETCH: begin
                w_im_req = 1'b1;
                if (ImReady) begin
                    w_ir_wr      = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_TRAP;
                    w_trap_set   = 1'b1;
                    w_trap_cause = c_TC_IFETCH;
                end
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    w_next_state = ST_TRAP;
                    w_trap_set   = 1'b1;
                    w_trap_cause = c_TC_ILLEGAL;
                end else begin
                    w_next_state = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                w_ctrl_en = 1'b1;
                case (w_cls)
                    CLS_BRANCH: begin
                        w_pc_wr      = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
                    default:             w_next_state = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                w_ctrl_en = 1'b1;
                w_dm_req  = 1'b1;
                w_dm_wr   = (w_cls == CLS_STORE);
                if (DmReady) begin
                    if (w_cls == CLS_STORE) begin
                        w_pc_wr      = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_WRITEBACK;
                    end
                end else if (w_timeout) begin
                    w_next_state = ST_TRAP;
                    w_trap_set   = 1'b1;
                    w_trap_cause = c_TC_DATA;
                end
            end
            ST_WRITEBACK: begin
                w_ctrl_en    = 1'b1;
                w_ru_wr      = 1'b1;
                w_pc_wr      = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_TRAP: w_next_state = ST_TRAP;
            default: w_next_state = ST_FETCH;
        endcase
    end

    // Strobes are forced low while reset is held
    assign ImReq = w_im_req & ~rst;
    assign IrWr  = w_ir_wr  & ~rst;
    assign PcWr  = w_pc_wr  & ~rst;
    assign DmReq = w_dm_req & ~rst;
    assign DmWr  = w_dm_wr  & ~rst;
    assign RuWr  = w_ru_wr  & ~rst;

    assign w_ctrl_out  = w_ctrl_en ? w_dec_ctrl : '0;
    assign ALUOp       = w_ctrl_out.alu_op;
    assign Immsrc      = w_ctrl_out.imm_src;
    assign ALUAsrc     = w_ctrl_out.alu_a_src;
    assign ALUBsrc     = w_ctrl_out.alu_b_src;
    assign BUOp        = w_ctrl_out.bu_op;
    assign RuDataWrsrc = w_ctrl_out.ru_data_wr_src;
    assign DmCtrl      = (r_state == ST_MEM) ? func3 : 3'b000;

    assign Trap      = r_trap;
    assign TrapCause = r_trap_cause;
    assign RetireCnt = r_retire_cnt + CNT_W'(w_retire);

endmodule
`default_nettype wire

// File: tb/tb_cu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_cu_multicycle
// Description : Self-checking bench for cu_multicycle (tables, random, corners).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cu_multicycle;

    localparam int c_TIMEOUT = 16;
    localparam int c_CNT_W   = 4;

    localparam logic [2:0] K_WB = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_BR = 3'd3, K_ILL = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] Opcode = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic ImReady = 1'b0;
    logic DmReady = 1'b0;
    logic ImReq, IrWr, PcWr, DmReq, DmWr, ALUAsrc, ALUBsrc, RuWr, Trap;
    logic [2:0] DmCtrl, Immsrc;
    logic [3:0] ALUOp;
    logic [4:0] BUOp;
    logic [1:0] RuDataWrsrc, TrapCause;
    logic [c_CNT_W-1:0] RetireCnt;

    cu_multicycle #(
        .MEM_TIMEOUT (c_TIMEOUT),
        .CNT_W       (c_CNT_W),
        .SUPPORT_UI  (1'b1)
    ) dut (
        .clk (clk), .rst (rst), .Opcode (Opcode), .func3 (func3), .func7 (func7),
        .ImReady (ImReady), .DmReady (DmReady), .ImReq (ImReq), .IrWr (IrWr),
        .PcWr (PcWr), .DmReq (DmReq), .DmWr (DmWr), .DmCtrl (DmCtrl), .ALUOp (ALUOp),
        .Immsrc (Immsrc), .ALUAsrc (ALUAsrc), .ALUBsrc (ALUBsrc), .BUOp (BUOp),
        .RuWr (RuWr), .RuDataWrsrc (RuDataWrsrc), .Trap (Trap), .TrapCause (TrapCause),
        .RetireCnt (RetireCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       a;
        logic       b;
        logic [4:0] bu;
        logic [1:0] wr;
    } exp_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        exp_t       e;
    } vec_t;

    vec_t tbl[$];
    int   checks  = 0;
    int   errors  = 0;
    int   retired = 0;

    function automatic logic [27:0] pk(
        input logic imreq, input logic irwr, input logic pcwr, input logic dmreq,
        input logic dmwr, input logic [2:0] dmctrl, input logic [3:0] alu,
        input logic [2:0] imm, input logic a, input logic b, input logic [4:0] bu,
        input logic ruwr, input logic [1:0] wr, input logic trap, input logic [1:0] cause);
        return {imreq, irwr, pcwr, dmreq, dmwr, dmctrl, alu, imm, a, b, bu, ruwr, wr, trap, cause};
    endfunction

    function automatic logic [27:0] v_fetch(input logic irwr);
        return pk(1'b1, irwr, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    endfunction

    function automatic logic [27:0] v_trap(input logic [1:0] cause);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, cause);
    endfunction

    function automatic logic [27:0] v_ctrl(input exp_t e, input logic pcwr, input logic dmreq,
                                           input logic dmwr, input logic [2:0] dmctrl, input logic ruwr);
        return pk(1'b0, 1'b0, pcwr, dmreq, dmwr, dmctrl, e.alu, e.imm, e.a, e.b, e.bu, ruwr, e.wr, 1'b0, 2'd0);
    endfunction

    logic [27:0] w_act;
    assign w_act = pk(ImReq, IrWr, PcWr, DmReq, DmWr, DmCtrl, ALUOp, Immsrc, ALUAsrc, ALUBsrc,
                      BUOp, RuWr, RuDataWrsrc, Trap, TrapCause);

    // Reference decode written per mnemonic from the instruction-set rules
    function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        exp_t e;
        logic shamt_ok;
        e = '0;
        e.kind = K_ILL;
        shamt_ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00) begin e.kind = K_WB; e.alu = {1'b0, f3}; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin e.kind = K_WB; e.alu = 4'b1000; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin e.kind = K_WB; e.alu = 4'b1101; end
            end
            7'b0010011: if (shamt_ok) begin
                e.kind = K_WB; e.b = 1'b1;
                e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'b1101 : {1'b0, f3};
            end
            7'b0000011: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                e.kind = K_LOAD; e.b = 1'b1; e.wr = 2'b01;
            end
            7'b0100011: if (f3 <= 3'd2) begin e.kind = K_STORE; e.b = 1'b1; e.imm = 3'b001; end
            7'b1100011: if (!(f3 inside {3'd2, 3'd3})) begin
                e.kind = K_BR; e.a = 1'b1; e.b = 1'b1; e.imm = 3'b101; e.bu = {2'b01, f3};
            end
            7'b1101111: begin e.kind = K_WB; e.a = 1'b1; e.b = 1'b1; e.imm = 3'b110; e.bu = 5'b10000; e.wr = 2'b10; end
            7'b1100111: begin e.kind = K_WB; e.b = 1'b1; e.bu = 5'b10000; e.wr = 2'b10; end
            7'b0110111: begin e.kind = K_WB; e.alu = 4'b1111; e.b = 1'b1; e.imm = 3'b010; end
            7'b0010111: begin e.kind = K_WB; e.a = 1'b1; e.b = 1'b1; e.imm = 3'b010; end
            default: e.kind = K_ILL;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance past the rising edge
    task automatic cyc(input string name, input logic [27:0] exp, input logic retire_now);
        logic [c_CNT_W-1:0] er;
        er = c_CNT_W'(retired + (retire_now ? 1 : 0));
        @(negedge clk);
        chk({name, " outputs"}, w_act, exp);
        chk({name, " retirecnt"}, 28'(RetireCnt), 28'(er));
        if (retire_now) retired++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ImReady = 1'b0;
        DmReady = 1'b0;
        #1;
        retired = 0;
        @(negedge clk);
        chk("reset outputs", w_act, 28'd0);
        chk("reset retirecnt", 28'(RetireCnt), 28'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input exp_t e, input int imw, input int dmw);
        logic is_st;
        Opcode = op; func3 = f3; func7 = f7;
        for (int i = 0; i <= imw; i++) begin
            ImReady = (i == imw);
            cyc({tag, " fetch"}, v_fetch(i == imw), 1'b0);
        end
        ImReady = 1'b0;
        cyc({tag, " decode"}, 28'd0, 1'b0);
        if (e.kind == K_ILL) begin
            for (int i = 0; i < 3; i++) begin
                ImReady = 1'($urandom);
                DmReady = 1'($urandom);
                cyc({tag, " illegal trap"}, v_trap(2'd1), 1'b0);
            end
            do_reset();
            return;
        end
        if (e.kind == K_BR) begin
            cyc({tag, " branch execute"}, v_ctrl(e, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), 1'b1);
            return;
        end
        cyc({tag, " execute"}, v_ctrl(e, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
        if (e.kind == K_LOAD || e.kind == K_STORE) begin
            is_st = (e.kind == K_STORE);
            for (int j = 0; j <= dmw; j++) begin
                DmReady = (j == dmw);
                cyc({tag, " mem"}, v_ctrl(e, is_st && (j == dmw), 1'b1, is_st, f3, 1'b0),
                    is_st && (j == dmw));
            end
            DmReady = 1'b0;
            if (is_st) return;
        end
        cyc({tag, " writeback"}, v_ctrl(e, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1), 1'b1);
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] kind, input logic [3:0] alu, input logic [2:0] imm,
                           input logic a, input logic b, input logic [4:0] bu, input logic [1:0] wr);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7;
        v.e.kind = kind; v.e.alu = alu; v.e.imm = imm; v.e.a = a; v.e.b = b; v.e.bu = bu; v.e.wr = wr;
        tbl.push_back(v);
    endtask

    logic [6:0] op_list [0:8];

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        exp_t       e;

        //       opcode       f3     f7         kind     alu      imm     a     b     bu         wr
        add_vec(7'b0110011, 3'd0, 7'h00, K_WB,    4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // add
        add_vec(7'b0110011, 3'd0, 7'h20, K_WB,    4'b1000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // sub
        add_vec(7'b0110011, 3'd5, 7'h20, K_WB,    4'b1101, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // sra
        add_vec(7'b0110011, 3'd6, 7'h00, K_WB,    4'b0110, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // or
        add_vec(7'b0010011, 3'd5, 7'h20, K_WB,    4'b1101, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b00); // srai
        add_vec(7'b0010011, 3'd1, 7'h00, K_WB,    4'b0001, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b00); // slli
        add_vec(7'b0010011, 3'd7, 7'h2A, K_WB,    4'b0111, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b00); // andi
        add_vec(7'b0000011, 3'd2, 7'h00, K_LOAD,  4'b0000, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b01); // lw
        add_vec(7'b0100011, 3'd0, 7'h00, K_STORE, 4'b0000, 3'b001, 1'b0, 1'b1, 5'b00000, 2'b00); // sb
        add_vec(7'b1100011, 3'd0, 7'h00, K_BR,    4'b0000, 3'b101, 1'b1, 1'b1, 5'b01000, 2'b00); // beq
        add_vec(7'b1100011, 3'd7, 7'h11, K_BR,    4'b0000, 3'b101, 1'b1, 1'b1, 5'b01111, 2'b00); // bgeu
        add_vec(7'b1101111, 3'd3, 7'h05, K_WB,    4'b0000, 3'b110, 1'b1, 1'b1, 5'b10000, 2'b10); // jal
        add_vec(7'b1100111, 3'd0, 7'h00, K_WB,    4'b0000, 3'b000, 1'b0, 1'b1, 5'b10000, 2'b10); // jalr
        add_vec(7'b0110111, 3'd2, 7'h7F, K_WB,    4'b1111, 3'b010, 1'b0, 1'b1, 5'b00000, 2'b00); // lui
        add_vec(7'b0010111, 3'd4, 7'h01, K_WB,    4'b0000, 3'b010, 1'b1, 1'b1, 5'b00000, 2'b00); // auipc
        add_vec(7'b1111111, 3'd0, 7'h00, K_ILL,   4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // 0x7F
        add_vec(7'b0110011, 3'd0, 7'h01, K_ILL,   4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // bad f7
        add_vec(7'b0110011, 3'd1, 7'h20, K_ILL,   4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // alt f7 sll
        add_vec(7'b0010011, 3'd1, 7'h20, K_ILL,   4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // slli bad
        add_vec(7'b1100011, 3'd2, 7'h00, K_ILL,   4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // br f3 010
        add_vec(7'b0000011, 3'd6, 7'h00, K_ILL,   4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // load f3 110
        add_vec(7'b0100011, 3'd3, 7'h00, K_ILL,   4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00); // store f3 011

        op_list[0] = 7'b0110011; op_list[1] = 7'b0010011; op_list[2] = 7'b0000011;
        op_list[3] = 7'b0100011; op_list[4] = 7'b1100011; op_list[5] = 7'b1101111;
        op_list[6] = 7'b1100111; op_list[7] = 7'b0110111; op_list[8] = 7'b0010111;

        @(posedge clk);
        #1;
        do_reset();

        foreach (tbl[i]) run_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].e, 0, 0);

        // lw with three wait cycles on the data side: eight cycles end to end
        run_instr("lw wait3", 7'b0000011, 3'd2, 7'h00, tbl[7].e, 0, 3);
        // fetch ready arrives in the last permitted cycle: no trap
        run_instr("add im15", 7'b0110011, 3'd0, 7'h00, tbl[0].e, c_TIMEOUT - 1, 0);
        run_instr("sw dm15", 7'b0100011, 3'd2, 7'h00, ref_decode(7'b0100011, 3'd2, 7'h00), 1, c_TIMEOUT - 1);

        // fetch timeout
        Opcode = 7'b0110011; func3 = 3'd0; func7 = 7'h00;
        for (int i = 0; i < c_TIMEOUT; i++) begin
            ImReady = 1'b0;
            cyc("fetch wait", v_fetch(1'b0), 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            ImReady = 1'b1;
            cyc("fetch timeout trap", v_trap(2'd2), 1'b0);
        end
        do_reset();

        // data timeout on a load
        e = ref_decode(7'b0000011, 3'd4, 7'h00);
        Opcode = 7'b0000011; func3 = 3'd4; func7 = 7'h00;
        ImReady = 1'b1;
        cyc("lbu fetch", v_fetch(1'b1), 1'b0);
        ImReady = 1'b0;
        cyc("lbu decode", 28'd0, 1'b0);
        cyc("lbu execute", v_ctrl(e, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
        for (int i = 0; i < c_TIMEOUT; i++) cyc("lbu mem wait", v_ctrl(e, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0), 1'b0);
        for (int i = 0; i < 2; i++) begin
            DmReady = 1'b1;
            cyc("data timeout trap", v_trap(2'd3), 1'b0);
        end
        do_reset();

        // reset asserted while a store is waiting in MEM
        run_instr("pre add", 7'b0110011, 3'd4, 7'h00, ref_decode(7'b0110011, 3'd4, 7'h00), 0, 0);
        e = ref_decode(7'b0100011, 3'd1, 7'h00);
        Opcode = 7'b0100011; func3 = 3'd1; func7 = 7'h00;
        ImReady = 1'b1;
        cyc("sh fetch", v_fetch(1'b1), 1'b0);
        ImReady = 1'b0;
        cyc("sh decode", 28'd0, 1'b0);
        cyc("sh execute", v_ctrl(e, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
        cyc("sh mem wait", v_ctrl(e, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0), 1'b0);
        do_reset();
        run_instr("post reset add", 7'b0110011, 3'd0, 7'h00, tbl[0].e, 0, 0);

        // randomized instruction stream against the reference decode
        for (int n = 0; n < 80; n++) begin
            int imw, dmw;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_list[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            imw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, c_TIMEOUT - 1) : $urandom_range(0, 1);
            dmw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, c_TIMEOUT - 1) : $urandom_range(0, 1);
            run_instr($sformatf("rand%0d", n), op, f3, f7, ref_decode(op, f3, f7), imw, dmw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
